mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one 32-bit memory port between instruction fetch (A, read-only) and
//  data access (B, read/write). Owns the select of the shared Mux32Bit2To1
//  address/data muxes in front of the memory. Sequences each access as
//  grant -> issue -> wait LATENCY -> respond. Sits between the IF/MEM stages
//  and the unified memory.
// PARAMETERS
//  LATENCY  2  memory read latency, in edges, from the edge that launches MemEn
//              to the edge that samples MemRData; legal range 1..15
//  RR       1  1 = round-robin on simultaneous requests; 0 = fixed priority, B over A
// PORTS
//  Clk        in   1   clock; all state updates on rising edge
//  Reset      in   1   synchronous reset, active-high
//  ReqA       in   1   fetch request; hold with AddrA stable until AckA
//  AddrA      in   32  fetch address
//  ReqB       in   1   data request; hold with AddrB/WDataB/WeB stable until AckB
//  AddrB      in   32  data address
//  WDataB     in   32  data write value
//  WeB        in   1   1 = write, 0 = read
//  MemRData   in   32  memory read data
//  AckA       out  1   one-cycle completion pulse for A
//  AckB       out  1   one-cycle completion pulse for B
//  RData      out  32  read result; valid while AckX=1, held afterwards
//  MemSel     out  1   shared mux select: 0 = A, 1 = B
//  MemAddr    out  32  registered address to memory
//  MemWData   out  32  registered write data (0 when A owns the port)
//  MemEn      out  1   access strobe, high for the issue cycle only
//  MemWe      out  1   write strobe, high only with MemEn on B writes
//  Busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, all outputs 0, last-served pointer=A. Sync reset
//   mid-access abandons the access: no Ack, nothing latched, IDLE next cycle.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. 4-bit countdown cnt.
//  IDLE: samples Req. No Req -> stay; outputs hold, MemSel keeps last grant.
//   If any Req at edge e0: pick winner; latch AddrX, WData (B) or 0 (A), and
//   We (B) or 0 (A) into MemAddr, MemWData, MemWe. Set MemSel=winner,
//   MemEn=1, cnt=LATENCY; go to ACCESS.
//  Arbitration: single requester wins. Both requesting:
//   RR=1 -> the one not served last wins (first tie after reset goes to B).
//   RR=0 -> B wins.
//   Pointer updates on each grant.
//  ACCESS: MemEn and MemWe are cleared at the first edge (e0+1). cnt
//   decrements each edge. At the edge where cnt==1 (edge e0+LATENCY):
//   - read: RData <= MemRData
//   - write: RData unchanged
//   - go to RESP.
//   LATENCY=1: capture happens at e0+1, same edge that clears MemEn.
//  RESP: AckX high for exactly this cycle (X = MemSel); Req ignored; go to IDLE.
//  Throughput: at most one access per LATENCY+2 cycles.
//   A Req held through its Ack is treated as a new request in IDLE.
//  Only one Ack is ever high at a time. MemAddr, MemWData and MemSel stay
//   stable from issue until the next grant.
// TESTING
//  T1 Reset held 2 cycles with ReqA=ReqB=1 -> all outputs 0, Busy=0,
//     no MemEn; first grant occurs at the first edge after Reset falls.
//  T2 LATENCY=2, ReqA, AddrA=0x00400000, MemRData=0xDEADBEEF ->
//     MemEn=1, MemSel=0, MemAddr=0x00400000 in cycle 1; AckA=1,
//     RData=0xDEADBEEF in cycle 3; RData holds afterwards.
//  T3 RR=1, ReqA and ReqB held continuously -> grant order B,A,B,A;
//     Ack spacing 4 cycles; never AckA and AckB together.
//  T4 ReqB, WeB=1, AddrB=0x10010004, WDataB=0x12345678 -> MemWe=1
//     only in the issue cycle, MemSel=1, AckB pulses, RData unchanged.
//  T5 Reset asserted during ACCESS -> no Ack, IDLE next cycle; a later
//     ReqA completes normally with correct RData.
//  T6 RR=0, both held for 5 accesses -> all 5 grants to B, AckA never asserted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one 32-bit memory port between instruction fetch (A) and data access (B).
// Each access runs grant -> issue -> wait LATENCY edges -> one-cycle Ack response.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter bit          RR      = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqA,
    input  logic [31:0] AddrA,
    input  logic        ReqB,
    input  logic [31:0] AddrB,
    input  logic [31:0] WDataB,
    input  logic        WeB,
    input  logic [31:0] MemRData,
    output logic        AckA,
    output logic        AckB,
    output logic [31:0] RData,
    output logic        MemSel,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemEn,
    output logic        MemWe,
    output logic        Busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            last_b, last_b_n;
    logic            wr, wr_n;
    logic            grant_b_c;
    logic            ack_a_n, ack_b_n;
    logic [DW-1:0]   rdata_n;
    logic            sel_n;
    logic [DW-1:0]   addr_n;
    logic [DW-1:0]   wdata_n;
    logic            en_n;
    logic            we_n;
    logic            busy_n;

    // Winner selection; on a tie RR favours whoever was not served last.
    always_comb begin
        grant_b_c = ReqB;
        if (ReqA && ReqB) begin
            grant_b_c = RR ? !last_b : 1'b1;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        last_b_n = last_b;
        wr_n     = wr;
        ack_a_n  = 1'b0;
        ack_b_n  = 1'b0;
        rdata_n  = RData;
        sel_n    = MemSel;
        addr_n   = MemAddr;
        wdata_n  = MemWData;
        en_n     = MemEn;
        we_n     = MemWe;

        case (state)
            IDLE: begin
                if (ReqA || ReqB) begin
                    state_n  = ACCESS;
                    cnt_n    = CW'(LATENCY);
                    last_b_n = grant_b_c;
                    sel_n    = grant_b_c;
                    addr_n   = grant_b_c ? AddrB : AddrA;
                    wdata_n  = grant_b_c ? WDataB : '0;
                    wr_n     = grant_b_c & WeB;
                    we_n     = grant_b_c & WeB;
                    en_n     = 1'b1;
                end
            end
            ACCESS: begin
                en_n  = 1'b0;
                we_n  = 1'b0;
                cnt_n = cnt - CW'(1);
                // Strobes are already gone by now, so the latched wr decides capture.
                if (cnt == CW'(1)) begin
                    if (!wr) begin
                        rdata_n = MemRData;
                    end
                    ack_a_n = !MemSel;
                    ack_b_n = MemSel;
                    state_n = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            last_b   <= 1'b0;
            wr       <= 1'b0;
            AckA     <= 1'b0;
            AckB     <= 1'b0;
            RData    <= '0;
            MemSel   <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            MemEn    <= 1'b0;
            MemWe    <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            last_b   <= last_b_n;
            wr       <= wr_n;
            AckA     <= ack_a_n;
            AckB     <= ack_b_n;
            RData    <= rdata_n;
            MemSel   <= sel_n;
            MemAddr  <= addr_n;
            MemWData <= wdata_n;
            MemEn    <= en_n;
            MemWe    <= we_n;
            Busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: round-robin (u_rr) and fixed-priority (u_fp)
// instances share stimulus; responses of u_rr are tracked by a scoreboard queue.
module tb_mem_port_arbiter;

    localparam int unsigned LAT = 2;

    typedef struct {
        logic        req_a;
        logic        req_b;
        logic        we_b;
        logic [31:0] addr_a;
        logic [31:0] addr_b;
        logic [31:0] wdata_b;
        logic [31:0] mem_rdata;
        logic        exp_sel;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        sel;
        logic [31:0] rdata;
    } resp_t;

    logic        clk;
    logic        reset;
    logic        req_a, req_b, we_b;
    logic [31:0] addr_a, addr_b, wdata_b, mem_rdata;

    logic        ack_a_r, ack_b_r, sel_r, en_r, we_r, busy_r;
    logic [31:0] rdata_r, addr_r, wdata_r;
    logic        ack_a_f, ack_b_f, sel_f, en_f, we_f, busy_f;
    logic [31:0] rdata_f, addr_f, wdata_f;

    int checks   = 0;
    int failures = 0;
    resp_t sb[$];
    vec_t  vecs[9];

    mem_port_arbiter #(.LATENCY(LAT), .RR(1'b1)) u_rr (
        .Clk(clk), .Reset(reset),
        .ReqA(req_a), .AddrA(addr_a),
        .ReqB(req_b), .AddrB(addr_b), .WDataB(wdata_b), .WeB(we_b),
        .MemRData(mem_rdata),
        .AckA(ack_a_r), .AckB(ack_b_r), .RData(rdata_r),
        .MemSel(sel_r), .MemAddr(addr_r), .MemWData(wdata_r),
        .MemEn(en_r), .MemWe(we_r), .Busy(busy_r)
    );

    mem_port_arbiter #(.LATENCY(LAT), .RR(1'b0)) u_fp (
        .Clk(clk), .Reset(reset),
        .ReqA(req_a), .AddrA(addr_a),
        .ReqB(req_b), .AddrB(addr_b), .WDataB(wdata_b), .WeB(we_b),
        .MemRData(mem_rdata),
        .AckA(ack_a_f), .AckB(ack_b_f), .RData(rdata_f),
        .MemSel(sel_f), .MemAddr(addr_f), .MemWData(wdata_f),
        .MemEn(en_f), .MemWe(we_f), .Busy(busy_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every Ack of the round-robin instance must match the oldest pending entry.
    always @(negedge clk) begin
        if (ack_a_f === 1'b1 || ack_b_f === 1'b1) begin
            chk("fp_ack_exclusive", 32'(ack_a_f & ack_b_f), 32'd0);
        end
        if (ack_a_r === 1'b1 || ack_b_r === 1'b1) begin
            chk("rr_ack_exclusive", 32'(ack_a_r & ack_b_r), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_ack actual=ack_a%0b_ack_b%0b expected=none t=%0t",
                         ack_a_r, ack_b_r, $time);
            end else begin
                resp_t e;
                e = sb.pop_front();
                chk("sb_ack_sel", 32'(ack_b_r), 32'(e.sel));
                chk("sb_rdata", rdata_r, e.rdata);
            end
        end
    end

    task automatic drop_reqs();
        req_a = 1'b0;
        req_b = 1'b0;
        we_b  = 1'b0;
    endtask

    // One complete transaction from IDLE, checked cycle by cycle.
    task automatic run_txn(input vec_t v);
        req_a = v.req_a; req_b = v.req_b; we_b = v.we_b;
        addr_a = v.addr_a; addr_b = v.addr_b; wdata_b = v.wdata_b;
        mem_rdata = ~v.mem_rdata;
        @(negedge clk);
        chk("issue_en", 32'(en_r), 32'd1);
        chk("issue_sel", 32'(sel_r), 32'(v.exp_sel));
        chk("issue_addr", addr_r, v.exp_addr);
        chk("issue_wdata", wdata_r, v.exp_wdata);
        chk("issue_we", 32'(we_r), 32'(v.exp_we));
        chk("issue_busy", 32'(busy_r), 32'd1);
        sb.push_back('{sel: v.exp_sel, rdata: v.exp_rdata});
        mem_rdata = (LAT == 1) ? v.mem_rdata : ~v.mem_rdata;
        for (int k = 1; k < int'(LAT); k++) begin
            @(negedge clk);
            chk("access_en", 32'(en_r), 32'd0);
            chk("access_we", 32'(we_r), 32'd0);
            chk("access_noack", 32'(ack_a_r | ack_b_r), 32'd0);
            chk("access_busy", 32'(busy_r), 32'd1);
            mem_rdata = (k == int'(LAT) - 1) ? v.mem_rdata : ~v.mem_rdata;
        end
        @(negedge clk);
        mem_rdata = ~v.mem_rdata;
        chk("resp_ack", {30'd0, ack_b_r, ack_a_r}, v.exp_sel ? 32'd2 : 32'd1);
        drop_reqs();
        @(negedge clk);
        chk("idle_busy", 32'(busy_r), 32'd0);
        chk("idle_noack", 32'(ack_a_r | ack_b_r), 32'd0);
        chk("idle_rdata_held", rdata_r, v.exp_rdata);
        chk("idle_addr_held", addr_r, v.exp_addr);
        chk("idle_sel_held", 32'(sel_r), 32'(v.exp_sel));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{req_a:1, req_b:0, we_b:0, addr_a:32'h0040_0000, addr_b:32'h0, wdata_b:32'h0,
                    mem_rdata:32'hDEAD_BEEF, exp_sel:0, exp_addr:32'h0040_0000, exp_wdata:32'h0,
                    exp_we:0, exp_rdata:32'hDEAD_BEEF};
        vecs[1] = '{req_a:0, req_b:1, we_b:1, addr_a:32'h0, addr_b:32'h1001_0004, wdata_b:32'h1234_5678,
                    mem_rdata:32'h0BAD_F00D, exp_sel:1, exp_addr:32'h1001_0004, exp_wdata:32'h1234_5678,
                    exp_we:1, exp_rdata:32'hDEAD_BEEF};
        vecs[2] = '{req_a:1, req_b:1, we_b:0, addr_a:32'h0040_0010, addr_b:32'h1001_0020, wdata_b:32'h0,
                    mem_rdata:32'h0123_4567, exp_sel:0, exp_addr:32'h0040_0010, exp_wdata:32'h0,
                    exp_we:0, exp_rdata:32'h0123_4567};
        vecs[3] = '{req_a:1, req_b:1, we_b:0, addr_a:32'h0040_0014, addr_b:32'h1001_0024, wdata_b:32'h5555_5555,
                    mem_rdata:32'h89AB_CDEF, exp_sel:1, exp_addr:32'h1001_0024, exp_wdata:32'h5555_5555,
                    exp_we:0, exp_rdata:32'h89AB_CDEF};
        vecs[4] = '{req_a:0, req_b:1, we_b:0, addr_a:32'h0, addr_b:32'h1001_FFFC, wdata_b:32'h0,
                    mem_rdata:32'hFFFF_FFFF, exp_sel:1, exp_addr:32'h1001_FFFC, exp_wdata:32'h0,
                    exp_we:0, exp_rdata:32'hFFFF_FFFF};
        vecs[5] = '{req_a:1, req_b:1, we_b:1, addr_a:32'h0040_0018, addr_b:32'h1001_0028, wdata_b:32'hCAFE_BABE,
                    mem_rdata:32'h8000_0001, exp_sel:0, exp_addr:32'h0040_0018, exp_wdata:32'h0,
                    exp_we:0, exp_rdata:32'h8000_0001};
        vecs[6] = '{req_a:1, req_b:1, we_b:1, addr_a:32'h0040_0018, addr_b:32'h1001_0028, wdata_b:32'hCAFE_BABE,
                    mem_rdata:32'h7777_7777, exp_sel:1, exp_addr:32'h1001_0028, exp_wdata:32'hCAFE_BABE,
                    exp_we:1, exp_rdata:32'h8000_0001};
        vecs[7] = '{req_a:1, req_b:0, we_b:0, addr_a:32'hFFFF_FFFC, addr_b:32'h0, wdata_b:32'h0,
                    mem_rdata:32'h0000_0000, exp_sel:0, exp_addr:32'hFFFF_FFFC, exp_wdata:32'h0,
                    exp_we:0, exp_rdata:32'h0000_0000};
        vecs[8] = '{req_a:1, req_b:0, we_b:0, addr_a:32'h0040_0200, addr_b:32'h0, wdata_b:32'h0,
                    mem_rdata:32'h5A5A_5A5A, exp_sel:0, exp_addr:32'h0040_0200, exp_wdata:32'h0,
                    exp_we:0, exp_rdata:32'h5A5A_5A5A};

        // Reset held two cycles with both requests pending.
        reset = 1'b1;
        req_a = 1'b1; req_b = 1'b1; we_b = 1'b0;
        addr_a = 32'h0040_0040; addr_b = 32'h1001_0040; wdata_b = 32'h0;
        mem_rdata = 32'hEEEE_EEEE;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_en", 32'(en_r | en_f), 32'd0);
            chk("rst_busy", 32'(busy_r | busy_f), 32'd0);
            chk("rst_ack", 32'(ack_a_r | ack_b_r | ack_a_f | ack_b_f), 32'd0);
            chk("rst_sel_we", 32'(sel_r | we_r | sel_f | we_f), 32'd0);
            chk("rst_addr", addr_r | addr_f, 32'd0);
            chk("rst_wdata", wdata_r | wdata_f, 32'd0);
            chk("rst_rdata", rdata_r | rdata_f, 32'd0);
        end
        reset = 1'b0;

        // Both held for five accesses: RR alternates B,A,B,..., fixed priority always B.
        for (int c = 1; c <= 20; c++) begin
            int k, p;
            logic exp_sel;
            k = (c - 1) / 4;
            p = (c - 1) % 4;
            exp_sel = (k % 2 == 0);
            @(negedge clk);
            case (p)
                0: begin
                    chk("cont_issue_en_rr", 32'(en_r), 32'd1);
                    chk("cont_issue_en_fp", 32'(en_f), 32'd1);
                    chk("cont_sel_rr", 32'(sel_r), 32'(exp_sel));
                    chk("cont_sel_fp", 32'(sel_f), 32'd1);
                    chk("cont_addr_rr", addr_r, exp_sel ? 32'h1001_0040 : 32'h0040_0040);
                    chk("cont_busy", 32'(busy_r & busy_f), 32'd1);
                    sb.push_back('{sel: exp_sel, rdata: 32'h1111_0000 + 32'(k)});
                    mem_rdata = 32'hEEEE_0000 | 32'(k);
                end
                1: begin
                    chk("cont_access_en", 32'(en_r | en_f), 32'd0);
                    chk("cont_access_noack", 32'(ack_a_r | ack_b_r | ack_a_f | ack_b_f), 32'd0);
                    mem_rdata = 32'h1111_0000 + 32'(k);
                end
                2: begin
                    chk("cont_ack_rr", {30'd0, ack_b_r, ack_a_r}, exp_sel ? 32'd2 : 32'd1);
                    chk("cont_ack_fp", {30'd0, ack_b_f, ack_a_f}, 32'd2);
                    chk("cont_rdata_fp", rdata_f, 32'h1111_0000 + 32'(k));
                    mem_rdata = 32'hEEEE_0000 | 32'(k);
                    if (k == 4) drop_reqs();
                end
                default: begin
                    chk("cont_idle_busy", 32'(busy_r | busy_f), 32'd0);
                    chk("cont_idle_noack", 32'(ack_a_r | ack_b_r | ack_a_f | ack_b_f), 32'd0);
                end
            endcase
        end

        // Table-driven single transactions on the round-robin instance.
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
        end

        // Reset in the middle of an access abandons it.
        req_a = 1'b1; addr_a = 32'h0040_0300; mem_rdata = 32'h3333_3333;
        @(negedge clk);
        chk("abort_issue_en", 32'(en_r), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy_r), 32'd0);
        chk("abort_en", 32'(en_r), 32'd0);
        chk("abort_addr", addr_r, 32'd0);
        chk("abort_rdata", rdata_r, 32'd0);
        reset = 1'b0;
        drop_reqs();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_noack", 32'(ack_a_r | ack_b_r | busy_r), 32'd0);
        end
        run_txn(vecs[8]);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
